// File: rtl/rf_mp.sv
`default_nettype none
// ============================================================================
//  Module   : rf_mp
//  Brief    : Parametrised multi-port integer register file with synchronous
//             read, write-through bypass and a per-register busy scoreboard.
//             Register 0 reads as zero. Numbers >= NREG are ignored on write
//             and read back as zero.
//  Revision : 1.0  initial release
// ============================================================================
module rf_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    parameter int AW   = 5
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NRD*AW-1:0]    RNUM,
    output logic [NRD*XLEN-1:0]  RDATA,
    output logic [NRD-1:0]       RBUSY,
    input  logic [NWR-1:0]       WEN,
    input  logic [NWR*AW-1:0]    WNUM,
    input  logic [NWR*XLEN-1:0]  WDATA,
    input  logic                 SB_SET,
    input  logic [AW-1:0]        SB_NUM
);

    // Register 0 is never stored; only entries 1..NREG-1 exist.
    logic [XLEN-1:0]     r_regs_q [1:NREG-1];
    logic [XLEN-1:0]     w_regs_d [1:NREG-1];
    logic [NREG-1:1]     r_busy_q;
    logic [NREG-1:1]     w_busy_d;
    logic [NRD*XLEN-1:0] r_rdata_q;
    logic [NRD*XLEN-1:0] w_rdata_d;
    logic [NRD-1:0]      r_rbusy_q;
    logic [NRD-1:0]      w_rbusy_d;

    assign RDATA = r_rdata_q;
    assign RBUSY = r_rbusy_q;

    // Next register/scoreboard state: later write ports override earlier
    // ones, a write retires the busy bit, and a same-edge set re-arms it.
    // Iterating only over existing registers drops zero and out-of-range
    // numbers without any explicit range compare.
    always_comb begin
        w_regs_d = r_regs_q;
        w_busy_d = r_busy_q;
        for (int r = 1; r < NREG; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (WEN[j] && (WNUM[j*AW +: AW] == AW'(r))) begin
                    w_regs_d[r] = WDATA[j*XLEN +: XLEN];
                    w_busy_d[r] = 1'b0;
                end
            end
            if (SB_SET && (SB_NUM == AW'(r))) begin
                w_busy_d[r] = 1'b1;
            end
        end
    end

    // Read from the post-update state so data and busy reflect this edge's
    // writes (bypass); unmatched numbers (0 or >= NREG) read as zero.
    always_comb begin
        w_rdata_d = '0;
        w_rbusy_d = '0;
        for (int i = 0; i < NRD; i++) begin
            for (int r = 1; r < NREG; r++) begin
                if (RNUM[i*AW +: AW] == AW'(r)) begin
                    w_rdata_d[i*XLEN +: XLEN] = w_regs_d[r];
                    w_rbusy_d[i]              = w_busy_d[r];
                end
            end
        end
    end

    // State and read-output registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int r = 1; r < NREG; r++) begin
                r_regs_q[r] <= '0;
            end
            r_busy_q  <= '0;
            r_rdata_q <= '0;
            r_rbusy_q <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                r_regs_q[r] <= w_regs_d[r];
            end
            r_busy_q  <= w_busy_d;
            r_rdata_q <= w_rdata_d;
            r_rbusy_q <= w_rbusy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_mp
//  Brief    : Self-checking bench for rf_mp (NREG=24, NRD=2, NWR=2) using
//             directed scenarios plus randomized traffic against an array
//             model of the register file and scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf_mp;

    localparam int XLEN = 32;
    localparam int NREG = 24;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                 CLK = 1'b0;
    logic                 RST_N;
    logic [NRD*AW-1:0]    RNUM;
    logic [NRD*XLEN-1:0]  RDATA;
    logic [NRD-1:0]       RBUSY;
    logic [NWR-1:0]       WEN;
    logic [NWR*AW-1:0]    WNUM;
    logic [NWR*XLEN-1:0]  WDATA;
    logic                 SB_SET;
    logic [AW-1:0]        SB_NUM;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural model: 32 slots so any 5-bit number can be looked up.
    logic [XLEN-1:0] m_reg  [0:31];
    bit              m_busy [0:31];

    rf_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .AW(AW)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .RNUM   (RNUM),
        .RDATA  (RDATA),
        .RBUSY  (RBUSY),
        .WEN    (WEN),
        .WNUM   (WNUM),
        .WDATA  (WDATA),
        .SB_SET (SB_SET),
        .SB_NUM (SB_NUM)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    function automatic bit valid_num(input logic [AW-1:0] n);
        return (n != 0) && (int'(n) < NREG);
    endfunction

    task automatic idle();
        WEN    = '0;
        WNUM   = '0;
        WDATA  = '0;
        SB_SET = 1'b0;
        SB_NUM = '0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] n, input logic [XLEN-1:0] d);
        WEN[p]              = 1'b1;
        WNUM[p*AW +: AW]    = n;
        WDATA[p*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] n);
        RNUM[p*AW +: AW] = n;
    endtask

    // Apply the current inputs across one rising edge, advance the model,
    // check both read ports, then return at the next falling edge idle.
    task automatic cycle();
        logic [AW-1:0]   n;
        logic [XLEN-1:0] exp_d;
        bit              exp_b;
        @(posedge CLK);
        for (int j = 0; j < NWR; j++) begin
            n = WNUM[j*AW +: AW];
            if (WEN[j] && valid_num(n)) begin
                m_reg[n]  = WDATA[j*XLEN +: XLEN];
                m_busy[n] = 1'b0;
            end
        end
        if (SB_SET && valid_num(SB_NUM)) m_busy[SB_NUM] = 1'b1;
        #1;
        for (int i = 0; i < NRD; i++) begin
            n     = RNUM[i*AW +: AW];
            exp_d = valid_num(n) ? m_reg[n] : '0;
            exp_b = valid_num(n) ? m_busy[n] : 1'b0;
            chk($sformatf("rdata%0d_x%0d", i, n), 64'(RDATA[i*XLEN +: XLEN]), 64'(exp_d));
            chk($sformatf("rbusy%0d_x%0d", i, n), 64'(RBUSY[i]), 64'(exp_b));
        end
        @(negedge CLK);
        idle();
    endtask

    initial begin
        RST_N = 1'b0;
        RNUM  = '0;
        idle();
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_rdata", 64'(RDATA), 64'd0);
        chk("reset_rbusy", 64'(RBUSY), 64'd0);
        RST_N = 1'b1;

        // Write then read one cycle later; x0 reads zero.
        wr(0, 5'd3, 32'h1234_5678);
        cycle();
        rd(0, 5'd3); rd(1, 5'd0);
        cycle();
        chk("latency_x3", 64'(RDATA[31:0]), 64'h1234_5678);
        chk("latency_x0", 64'(RDATA[63:32]), 64'h0);

        // Write-through bypass on the same edge.
        wr(0, 5'd7, 32'hA5A5_A5A5); rd(0, 5'd7);
        cycle();
        chk("bypass_x7", 64'(RDATA[31:0]), 64'hA5A5_A5A5);

        // Collision: higher port wins.
        wr(0, 5'd9, 32'h1); wr(1, 5'd9, 32'h2);
        cycle();
        rd(0, 5'd9);
        cycle();
        chk("collide_x9", 64'(RDATA[31:0]), 64'h2);

        // Scoreboard set, clear, set-wins, and x0 ignored.
        rd(0, 5'd4); SB_SET = 1'b1; SB_NUM = 5'd4;
        cycle();
        chk("sb_set_x4", 64'(RBUSY[0]), 64'd1);
        wr(0, 5'd4, 32'h0000_0044);
        cycle();
        chk("sb_clr_x4", 64'(RBUSY[0]), 64'd0);
        wr(1, 5'd4, 32'hCAFE_0004); SB_SET = 1'b1; SB_NUM = 5'd4;
        cycle();
        chk("sb_both_busy", 64'(RBUSY[0]), 64'd1);
        chk("sb_both_data", 64'(RDATA[31:0]), 64'hCAFE_0004);
        rd(0, 5'd0); SB_SET = 1'b1; SB_NUM = 5'd0;
        cycle();
        chk("sb_x0", 64'(RBUSY[0]), 64'd0);

        // Out-of-range write/read, x23 still works.
        wr(0, 5'd30, 32'h0000_FFFF); rd(0, 5'd30); SB_SET = 1'b1; SB_NUM = 5'd30;
        cycle();
        chk("oor_data", 64'(RDATA[31:0]), 64'h0);
        chk("oor_busy", 64'(RBUSY[0]), 64'd0);
        wr(0, 5'd23, 32'h2323_2323); rd(1, 5'd23); SB_SET = 1'b1; SB_NUM = 5'd23;
        cycle();
        chk("x23_data", 64'(RDATA[63:32]), 64'h2323_2323);
        chk("x23_busy", 64'(RBUSY[1]), 64'd1);

        // Asynchronous reset mid-run.
        wr(0, 5'd5, 32'hDEAD_BEEF); rd(0, 5'd5); SB_SET = 1'b1; SB_NUM = 5'd5;
        cycle();
        chk("pre_rst_x5", 64'(RDATA[31:0]), 64'hDEAD_BEEF);
        wr(0, 5'd6, 32'h6666_6666);
        RST_N = 1'b0;
        #2;
        chk("async_rst_rdata", 64'(RDATA), 64'd0);
        chk("async_rst_rbusy", 64'(RBUSY), 64'd0);
        model_reset();
        @(negedge CLK);
        idle();
        RST_N = 1'b1;
        rd(0, 5'd5); rd(1, 5'd6);
        cycle();
        chk("post_rst_x5", 64'(RDATA[31:0]), 64'h0);

        // Randomized traffic, reads biased toward registers being written.
        for (int k = 0; k < 400; k++) begin
            for (int j = 0; j < NWR; j++) begin
                WEN[j]                = ($urandom_range(0, 2) != 0);
                WNUM[j*AW +: AW]      = AW'($urandom_range(0, 31));
                WDATA[j*XLEN +: XLEN] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) WNUM[AW +: AW] = WNUM[0 +: AW];
            SB_SET = ($urandom_range(0, 1) != 0);
            SB_NUM = ($urandom_range(0, 3) == 0) ? WNUM[0 +: AW] : AW'($urandom_range(0, 31));
            for (int i = 0; i < NRD; i++) begin
                case ($urandom_range(0, 3))
                    0:       RNUM[i*AW +: AW] = WNUM[0 +: AW];
                    1:       RNUM[i*AW +: AW] = WNUM[AW +: AW];
                    default: RNUM[i*AW +: AW] = AW'($urandom_range(0, 31));
                endcase
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_mp.md
Name: rf_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write/dual-read pipeline register file.
- Sits in the decode/writeback stages of the RV32I pipeline.
- Adds configurable width, depth, read/write port count, and async reset clear.
- Adds synchronous read with write-through bypass and a per-register busy scoreboard for hazard detection.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; register 0 hardwired to zero; need not be a power of two.
- NRD, 2, number of read ports.
- NWR, 1, number of write ports (1..4).
- AW, 5, register-number width; must satisfy 2**AW >= NREG.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- RNUM  input  NRD*AW  read register numbers; port i uses bits [i*AW +: AW].
- RDATA  output  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- RBUSY  output  NRD  scoreboard busy flag of each read register, registered alongside RDATA.
- WEN  input  NWR  per-port write enable.
- WNUM  input  NWR*AW  write register numbers.
- WDATA  input  NWR*XLEN  write data.
- SB_SET  input  1  mark register SB_NUM busy (an instruction writing it has issued).
- SB_NUM  input  AW  register to mark busy.

Behaviour:
- Reset (RST_N=0, async, no CLK needed):
  - all registers cleared to 0;
  - all busy bits cleared;
  - RDATA = 0, RBUSY = 0.
  - Held while RST_N low. First update occurs on the first rising edge after deassertion.
- Register 0:
  - writes ignored; reads always 0;
  - SB_SET to 0 ignored; busy bit 0 is constant 0.
- Out-of-range numbers (>= NREG):
  - writes and SB_SET ignored;
  - reads return RDATA 0, RBUSY 0.
- Write:
  - On rising edge, for each port j with WEN[j]=1 and a valid nonzero WNUM, the register takes WDATA[j].
  - Same-edge collision (two ports, same register): the highest-indexed port wins.
- Read:
  - Latency 1. RNUM sampled on rising edge N; RDATA/RBUSY valid after edge N and held until edge N+1.
  - Write-through bypass: if any port writes the sampled register on edge N, RDATA returns that edge's winning WDATA, not the old value.
  - All read ports are independent; duplicate RNUM across ports is legal.
- Scoreboard:
  - Busy bit b[r] is set on an edge with SB_SET=1 and SB_NUM=r.
  - b[r] is cleared on an edge where any WEN writes r.
  - Set and clear of the same r on the same edge: set wins (a new producer supersedes the retiring one); the data write still occurs.
  - RBUSY[i] reflects b[RNUM_i] after that edge's updates, consistent with the RDATA bypass.
- No backpressure or handshake; every port acts every cycle it is enabled.
- RST_N asserted mid-operation: in-flight writes and set requests on that cycle are discarded.

Test Plan:
- Reset: drive RST_N=0 mid-run after writing x5=0xDEADBEEF; RDATA/RBUSY go to 0 immediately without a clock edge; after release, reading x5 -> 0.
- Write/read latency: write x3=0x12345678 on edge 1, RNUM0=3 on edge 2 -> RDATA0=0x12345678 after edge 2; RNUM1=0 -> 0.
- Bypass: WEN0=1, WNUM0=7, WDATA0=0xA5A5A5A5 with RNUM0=7 on the same edge -> RDATA0=0xA5A5A5A5 after that edge.
- Collision (NWR=2): both ports write x9, port0=0x1, port1=0x2 -> subsequent read of x9 = 0x2.
- Scoreboard:
  - SB_SET x4 -> RBUSY=1 on read of x4.
  - Write x4 -> RBUSY=0.
  - SB_SET x4 and write x4 on the same edge -> RBUSY=1 and RDATA = new data.
  - SB_SET x0 -> RBUSY stays 0.
- Out-of-range (NREG=24, AW=5): write x30=0xFFFF -> ignored; read x30 -> RDATA 0, RBUSY 0; x23 fully functional.
